// File: rtl/st_pkg.sv
// Shared definitions for the serial transmit engine: FSM state encoding and a
// constant-foldable ceiling-log2 helper used for counter and pointer widths.
package st_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } st_state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/st_word_fifo.sv
// Synchronous word FIFO with show-ahead read: pop_data always presents the
// oldest entry, so a pop consumes it on the same edge the reader captures it.
module st_word_fifo
  import st_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_w;
  logic             do_push;
  logic             do_pop;

  assign full_w  = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign do_push = push && (!full_w || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/serial_tx_engine.sv
// Single-clock serialiser: queues words in st_word_fifo and shifts each one out
// N bits per beat, every beat held for DIV clocks, MSB- or LSB-first per word.
module serial_tx_engine
  import st_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 1,
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Sample,
  input  logic             StartTx,
  input  logic             MsbFirst,
  output logic             Full,
  output logic             Overflow,
  output logic             TxBusy,
  output logic             TxDone,
  output logic             DoutValid,
  output logic [N-1:0]     Dout
);

  localparam int BEATS = WIDTH / N;
  localparam int BW    = clog2(BEATS + 1);
  localparam int DW    = clog2(DIV + 1);
  localparam int CW    = clog2(DEPTH) + 1;

  generate
    if ((WIDTH % N) != 0) begin : g_bad_lane
      $error("serial_tx_engine: WIDTH must be a multiple of N");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("serial_tx_engine: DEPTH must be a power of two >= 2");
    end
    if (DIV < 1) begin : g_bad_div
      $error("serial_tx_engine: DIV must be >= 1");
    end
  endgenerate

  st_state_t        state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             msb_reg, msb_next;
  logic [BW-1:0]    beat_reg, beat_next;
  logic [DW-1:0]    div_reg, div_next;
  logic [N-1:0]     dout_reg, dout_next;
  logic             overflow_reg, overflow_next;

  logic             fifo_pop;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] fifo_data;
  logic             full_w;
  logic [WIDTH-1:0] shifted_w;

  st_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .push      (Sample),
    .push_data (DataIn),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  function automatic logic [N-1:0] beat_of(input logic [WIDTH-1:0] word, input logic msb);
    return msb ? word[WIDTH-1 -: N] : word[N-1:0];
  endfunction

  assign full_w    = (fifo_count == CW'(DEPTH));
  assign fifo_pop  = (state_reg == ST_LOAD);
  assign shifted_w = msb_reg ? (shift_reg << N) : (shift_reg >> N);

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    msb_next      = msb_reg;
    beat_next     = beat_reg;
    div_next      = div_reg;
    dout_next     = dout_reg;
    overflow_next = Sample && full_w && !fifo_pop;

    case (state_reg)
      ST_IDLE: begin
        if (StartTx && !fifo_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        shift_next = fifo_data;
        msb_next   = MsbFirst;
        beat_next  = '0;
        div_next   = '0;
        dout_next  = beat_of(fifo_data, MsbFirst);
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_reg == DW'(DIV - 1)) begin
          div_next   = '0;
          shift_next = shifted_w;
          beat_next  = beat_reg + 1'b1;
          // Final beat keeps Dout unchanged through the DONE cycle.
          if (beat_reg == BW'(BEATS - 1)) begin
            state_next = ST_DONE;
          end else begin
            dout_next = beat_of(shifted_w, msb_reg);
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = (StartTx && !fifo_empty) ? ST_LOAD : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      msb_reg      <= 1'b0;
      beat_reg     <= '0;
      div_reg      <= '0;
      dout_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      msb_reg      <= msb_next;
      beat_reg     <= beat_next;
      div_reg      <= div_next;
      dout_reg     <= dout_next;
      overflow_reg <= overflow_next;
    end
  end

  assign Full      = full_w;
  assign Overflow  = overflow_reg;
  assign TxBusy    = (state_reg != ST_IDLE);
  assign TxDone    = (state_reg == ST_DONE);
  assign DoutValid = (state_reg == ST_SHIFT);
  assign Dout      = dout_reg;

endmodule
